// File: rtl/vec_op_sequencer.sv
// vec_op_sequencer: command-driven sequencer for the vector datapath.
// Takes one command at a time (add/mul/store/load), drives the register
// file, ALU and word-wide data memory, and pulses done (with err for an
// illegal op) when the command completes.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | waiting for a command, cmd_ready high
// S_ALU    | operands/op presented to the ALU for ALU_LAT cycles
// S_WB_LO  | write ALU low result into register 2
// S_WB_HI  | write ALU high result into register 3
// S_ST_LAT | read source register, capture it into the shadow vector
// S_ST     | write shadow vector to memory, one word per cycle
// S_LD     | issue memory reads, one word per cycle
// S_LD_DR  | collect the last read word
// S_LD_WB  | write assembled vector into destination register
// S_DONE   | completion pulse (err set for an illegal op)
module vec_op_sequencer #(
  parameter int VLEN    = 512,
  parameter int WORD    = 32,
  parameter int NWORDS  = 16,
  parameter int MEM_AW  = 9,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [1:0]        cmd_ra,
  input  logic [1:0]        cmd_rb,
  input  logic [1:0]        cmd_rd,
  input  logic [MEM_AW-1:0] cmd_addr,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [1:0]        rf_rd_addr1,
  output logic [1:0]        rf_rd_addr2,
  input  logic [VLEN-1:0]   rf_rd_data1,
  output logic [2:0]        alu_op,
  input  logic [VLEN-1:0]   alu_lo,
  input  logic [VLEN-1:0]   alu_hi,
  output logic              rf_we,
  output logic [1:0]        rf_wr_addr,
  output logic [VLEN-1:0]   rf_wr_data,
  output logic              mem_we,
  output logic              mem_re,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [WORD-1:0]   mem_wdata,
  input  logic [WORD-1:0]   mem_rdata
);

  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_ST  = 3'b010;
  localparam logic [2:0] OP_LD  = 3'b011;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE, S_ALU, S_WB_LO, S_WB_HI, S_ST_LAT, S_ST, S_LD, S_LD_DR, S_LD_WB, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [1:0]        ra_q, ra_d;
  logic [1:0]        rb_q, rb_d;
  logic [1:0]        rd_q, rd_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [VLEN-1:0]   vec_q, vec_d;
  logic              err_q, err_d;

  logic accept;
  logic last_word;

  assign accept    = cmd_valid && cmd_ready;
  assign last_word = (idx_q == IW'(NWORDS - 1));

  // State and latched-command registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      base_q  <= '0;
      idx_q   <= '0;
      lat_q   <= '0;
      vec_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      lat_q   <= lat_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; vec_q is shared as store shadow (shifts out at the top)
  // and load assembly buffer (shifts in at the bottom), so word 0 ends up in
  // the most significant slot either way.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    base_d  = base_q;
    idx_d   = idx_q;
    lat_d   = lat_q;
    vec_d   = vec_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          ra_d   = cmd_ra;
          rb_d   = cmd_rb;
          rd_d   = cmd_rd;
          base_d = cmd_addr;
          idx_d  = '0;
          lat_d  = LW'(ALU_LAT - 1);
          err_d  = 1'b0;
          case (cmd_op)
            OP_ADD, OP_MUL: state_d = S_ALU;
            OP_ST:          state_d = S_ST_LAT;
            OP_LD:          state_d = S_LD;
            default: begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_ALU: begin
        if (lat_q == '0) state_d = S_WB_LO;
        else             lat_d   = lat_q - 1'b1;
      end
      S_WB_LO:  state_d = S_WB_HI;
      S_WB_HI:  state_d = S_DONE;
      S_ST_LAT: begin
        vec_d   = rf_rd_data1;
        state_d = S_ST;
      end
      S_ST: begin
        vec_d = vec_q << WORD;
        idx_d = idx_q + 1'b1;
        if (last_word) state_d = S_DONE;
      end
      S_LD: begin
        // Read data lags the request by one cycle, so nothing to collect on word 0.
        if (idx_q != '0) vec_d = {vec_q[VLEN-WORD-1:0], mem_rdata};
        idx_d = idx_q + 1'b1;
        if (last_word) state_d = S_LD_DR;
      end
      S_LD_DR: begin
        vec_d   = {vec_q[VLEN-WORD-1:0], mem_rdata};
        state_d = S_LD_WB;
      end
      S_LD_WB:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath controls decoded purely from registered state and latched fields.
  always_comb begin
    cmd_ready   = (state_q == S_IDLE) && !rst;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    err         = (state_q == S_DONE) && err_q;
    rf_rd_addr1 = '0;
    rf_rd_addr2 = '0;
    alu_op      = OP_NOP;
    rf_we       = 1'b0;
    rf_wr_addr  = '0;
    rf_wr_data  = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state_q)
      S_ALU: begin
        rf_rd_addr1 = ra_q;
        rf_rd_addr2 = rb_q;
        alu_op      = op_q;
      end
      S_WB_LO: begin
        rf_rd_addr1 = ra_q;
        rf_rd_addr2 = rb_q;
        alu_op      = op_q;
        rf_we       = 1'b1;
        rf_wr_addr  = 2'd2;
        rf_wr_data  = alu_lo;
      end
      S_WB_HI: begin
        rf_rd_addr1 = ra_q;
        rf_rd_addr2 = rb_q;
        alu_op      = op_q;
        rf_we       = 1'b1;
        rf_wr_addr  = 2'd3;
        rf_wr_data  = alu_hi;
      end
      S_ST_LAT: rf_rd_addr1 = ra_q;
      S_ST: begin
        mem_we    = 1'b1;
        mem_addr  = base_q + MEM_AW'(idx_q);
        mem_wdata = vec_q[VLEN-1 -: WORD];
      end
      S_LD: begin
        mem_re   = 1'b1;
        mem_addr = base_q + MEM_AW'(idx_q);
      end
      S_LD_WB: begin
        rf_we      = 1'b1;
        rf_wr_addr = rd_q;
        rf_wr_data = vec_q;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/vec_op_sequencer.md
Name: vec_op_sequencer

Overview:
- Command-driven controller that sequences the vector datapath: 4 x 512-bit register file, ALU (add/mul producing low/high 512-bit results) and word-wide data memory.
- Accepts one command at a time over a valid/ready handshake.
- Issues ALU operations with writeback of low/high results to registers 2/3.
- Moves 512-bit vectors to and from memory as 16-word bursts.
- Sits between the instruction front end and the CPU datapath, replacing direct op/address driving.

Parameters:
- VLEN, 512, vector width in bits
- WORD, 32, memory word width in bits
- NWORDS, 16, words per vector (VLEN/WORD)
- MEM_AW, 9, memory word-address width
- ALU_LAT, 1, cycles ALU results need after operands/op are presented (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept (IDLE only)
- cmd_op  in  3  000 add, 001 mul, 010 store ra->mem, 011 load mem->rd; others illegal
- cmd_ra  in  2  source A register
- cmd_rb  in  2  source B register
- cmd_rd  in  2  load destination register
- cmd_addr  in  MEM_AW  base word address
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = illegal op
- busy  out  1  state != IDLE
- rf_rd_addr1  out  2  register read port 1 (combinational read)
- rf_rd_addr2  out  2  register read port 2
- rf_rd_data1  in  VLEN  read port 1 data
- alu_op  out  3  ALU op; 3'b111 (idle/no-op) outside ALU state
- alu_lo  in  VLEN  ALU low result
- alu_hi  in  VLEN  ALU high result
- rf_we  out  1  register write enable
- rf_wr_addr  out  2  register write address
- rf_wr_data  out  VLEN  register write data
- mem_we  out  1  memory word write
- mem_re  out  1  memory word read; data valid on mem_rdata the following cycle
- mem_addr  out  MEM_AW  memory word address
- mem_wdata  out  WORD  memory write word
- mem_rdata  in  WORD  memory read word

Behaviour:
- Reset: state IDLE, all outputs 0 except alu_op=3'b111; cmd_ready=0 while rst=1. Command fields latched at acceptance; inputs ignored afterwards.
- Handshake: accept on cycle where cmd_valid&&cmd_ready; cmd_ready=1 only in IDLE with rst=0. No command queuing.
- Cycle numbering: accept cycle = 0.
- ADD/MUL:
  - S_ALU for ALU_LAT cycles (1..ALU_LAT): rf_rd_addr1=ra, rf_rd_addr2=rb, alu_op=cmd_op.
  - S_WB_LO: rf_we=1, rf_wr_addr=2, data=alu_lo.
  - S_WB_HI: rf_we=1, rf_wr_addr=3, data=alu_hi.
  - Read addresses/op stay held through both WB states.
  - S_DONE: done=1, err=0. With ALU_LAT=1, done at cycle 4.
- STORE:
  - S_ST_LAT (cycle 1): rf_rd_addr1=ra; capture rf_rd_data1 into shadow.
  - S_ST (cycles 2..17): mem_we=1, mem_addr=base+i, mem_wdata=shadow word i, where word 0 = bits [511:480] and word 15 = bits [31:0].
  - S_DONE at cycle 18.
- LOAD:
  - S_LD (cycles 1..16): mem_re=1, mem_addr=base+i.
  - Capture mem_rdata in cycles 2..17, 17 being drain state S_LD_DR; word i fills bits [511-32i -: 32].
  - S_LD_WB (cycle 18): rf_we=1, rf_wr_addr=rd, data=assembled vector.
  - S_DONE at cycle 19.
- Illegal op: cycle 1 S_DONE with done=1, err=1; no rf/mem enables.
- Address arithmetic: base+i modulo 2^MEM_AW; base 510 wraps to 510,511,0..13.
- At most one of rf_we/mem_we/mem_re high per cycle. Registered outputs; no combinational path from cmd_* to datapath outputs.
- Reset mid-operation: next cycle IDLE, all enables 0; already-written words/registers are not rolled back; no done pulse.
- cmd_valid during busy: ignored, held by requester.
- Same register as ra and rd: legal.

Test Plan:
- Reset: rst high 2 cycles with cmd_valid=1 -> cmd_ready=0, all enables 0, alu_op=111; first cycle after release cmd_ready=1.
- ADD ra=0 (16x AAAAAAAA), rb=1 (11111111..00000000), ALU_LAT=1 -> reg2=alu_lo at cycle 2, reg3=alu_hi at cycle 3, done cycle 4, err=0.
- STORE ra=2, base=0 after MUL -> 16 consecutive mem_we at addrs 0..15; mem[0]=reg2[511:480], mem[15]=reg2[31:0]; done cycle 18.
- LOAD base=0, rd=0 -> mem_re addrs 0..15; reg0 equals concat mem[0..15]; done cycle 19; back-to-back command accepted cycle 20.
- Wrap: STORE base=9'd510 -> addrs 510,511,0..13. Illegal op 3'b101 -> done+err at cycle 1, no writes.
- Reset asserted at STORE cycle 8 -> mem_we low next cycle, no done, mem[0..6] written, IDLE after reset.
